// File: rtl/dht11_sensor_driver.sv
// Single-wire DHT11 read driver: start pulse, response handshake, 40-bit frame decode.
// Optional build macro CHECKSUM_CHECK_EN rejects frames whose checksum byte does not match.
module dht11_sensor_driver #(
  parameter int START_LOW_CYC  = 900000,
  parameter int RELEASE_CYC    = 1500,
  parameter int BIT_THRESH_CYC = 2500,
  parameter int TIMEOUT_CYC    = 5000
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        enable_sensor,
  inout  wire         sensor_data,
  output logic [39:0] data_sensor,
  output logic        data_valid,
  output logic        error,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  // Request/response protocol: a rising edge on enable_sensor is taken only
  // while idle; busy then stays high through the single-cycle data_valid or
  // error pulse that ends the read, and drops on the following clock.

  localparam int MAX_LR  = (START_LOW_CYC > RELEASE_CYC) ? START_LOW_CYC : RELEASE_CYC;
  localparam int MAX_TT  = (TIMEOUT_CYC > BIT_THRESH_CYC) ? TIMEOUT_CYC : BIT_THRESH_CYC;
  localparam int MAX_CYC = (MAX_LR > MAX_TT) ? MAX_LR : MAX_TT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] THRESH       = CNT_W'(BIT_THRESH_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT      = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       bit_idx_q;
  logic [39:0]      shift_q;
  logic [39:0]      data_q;
  logic             seen_rise_q;
  logic             drive_low_q;
  logic             valid_q;
  logic             error_q;
  logic             busy_q;
  logic             en_q;
  logic             sync1_q, sync2_q, sync3_q;

  logic start, rise, fall, timed_out;

  assign start     = enable_sensor & ~en_q;
  assign rise      = sync2_q & ~sync3_q;
  assign fall      = ~sync2_q & sync3_q;
  assign timed_out = (cnt_q >= TIMEOUT);

`ifdef CHECKSUM_CHECK_EN
  logic [7:0] sum;
  logic       checksum_ok;
  assign sum         = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
  assign checksum_ok = (sum == shift_q[7:0]);
`endif

  // Open-drain: the host only ever pulls low or lets the pull-up win.
  assign sensor_data = drive_low_q ? 1'b0 : 1'bz;

  assign data_sensor = data_q;
  assign data_valid  = valid_q;
  assign error       = error_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

  // Idle level of the line is high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= sensor_data;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      seen_rise_q <= 1'b0;
      drive_low_q <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      en_q    <= enable_sensor;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          cnt_q  <= '0;
          if (start) begin
            state_q     <= S_START_LOW;
            drive_low_q <= 1'b1;
            bit_idx_q   <= '0;
            shift_q     <= '0;
          end
        end
        S_START_LOW: begin
          if (cnt_q == START_LAST) begin
            state_q     <= S_RELEASE;
            drive_low_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == RELEASE_LAST) begin
            state_q <= S_RESP_LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP_LOW: begin
          if (!sync2_q) begin
            state_q     <= S_RESP_HIGH;
            seen_rise_q <= 1'b0;
            cnt_q       <= '0;
          end else if (timed_out) begin
            state_q <= S_FAIL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The response high phase must be seen before its falling edge counts.
        S_RESP_HIGH: begin
          if (seen_rise_q && fall) begin
            state_q <= S_BIT_LOW;
            cnt_q   <= '0;
          end else if (timed_out) begin
            state_q <= S_FAIL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (rise) seen_rise_q <= 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (rise) begin
            state_q <= S_BIT_HIGH;
            cnt_q   <= '0;
          end else if (timed_out) begin
            state_q <= S_FAIL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BIT_HIGH: begin
          if (fall) begin
            shift_q   <= {shift_q[38:0], (cnt_q > THRESH)};
            bit_idx_q <= bit_idx_q + 1'b1;
            cnt_q     <= '0;
            state_q   <= (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (timed_out) begin
            state_q <= S_FAIL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          cnt_q <= '0;
`ifdef CHECKSUM_CHECK_EN
          state_q <= checksum_ok ? S_DONE : S_FAIL;
`else
          state_q <= S_DONE;
`endif
        end
        S_DONE: begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          error_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          drive_low_q <= 1'b0;
          busy_q      <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_driver.sv
// Bench for dht11_sensor_driver: behavioural sensor model on a pulled-up line,
// directed plan cases plus randomized frames checked against a checksum-rule model.
module tb_dht11_sensor_driver;

  localparam int START_LOW = 20;
  localparam int RELEASE   = 5;
  localparam int THRESH    = 10;
  localparam int TIMEOUT   = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        enable    = 1'b0;
  logic        sense_low = 1'b0;
  wire         sensor_line;
  logic [39:0] data_sensor;
  logic        data_valid, error, busy;
  logic [3:0]  state_dbg;

  pullup (sensor_line);
  assign sensor_line = sense_low ? 1'b0 : 1'bz;

  dht11_sensor_driver #(
    .START_LOW_CYC (START_LOW),
    .RELEASE_CYC   (RELEASE),
    .BIT_THRESH_CYC(THRESH),
    .TIMEOUT_CYC   (TIMEOUT)
  ) dut (
    .clock_50Mhz  (clk),
    .reset        (rst),
    .enable_sensor(enable),
    .sensor_data  (sensor_line),
    .data_sensor  (data_sensor),
    .data_valid   (data_valid),
    .error        (error),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: frames the model says must be accepted, in order
  logic [39:0] exp_q[$];
  logic [39:0] model_data = '0;
  int dv_cnt = 0, err_cnt = 0, both_cnt = 0, state_moves = 0;
  logic [3:0] state_prev = '0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      chk("valid_has_expectation", 40'(exp_q.size() != 0), 40'd1);
      if (exp_q.size() != 0) chk("frame_scoreboard", data_sensor, exp_q.pop_front());
    end
    if (error) err_cnt++;
    if (data_valid && error) both_cnt++;
    if (state_dbg !== state_prev) state_moves++;
    state_prev = state_dbg;
  end

  // reference model: checksum rule on whole bytes, plain integer arithmetic
  function automatic logic model_accept(input logic [39:0] f);
`ifdef CHECKSUM_CHECK_EN
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
`else
    return (f !== 40'bx);
`endif
  endfunction

  function automatic logic [39:0] make_frame(input bit good);
    int b[4];
    int s;
    int cs;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = int'($urandom_range(0, 255));
      s += b[i];
    end
    cs = good ? (s % 256) : ((s + int'($urandom_range(1, 255))) % 256);
    return {b[0][7:0], b[1][7:0], b[2][7:0], b[3][7:0], cs[7:0]};
  endfunction

  // driver tasks
  task automatic start_txn();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_host_start();
    int n;
    n = 0;
    while (sensor_line !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("host_pulls_low", 40'(sensor_line), 40'd0);
    n = 0;
    while (sensor_line === 1'b0 && n < START_LOW + 50) begin
      n++;
      @(negedge clk);
    end
    chk("start_low_len", 40'(n), 40'(START_LOW));
  endtask

  task automatic sensor_hold(input logic low, input int cyc);
    sense_low = low;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f, input bit rnd, input int retrig_bit);
    int lo, hi;
    sensor_hold(1'b0, 2);
    sensor_hold(1'b1, rnd ? int'($urandom_range(12, 16)) : 15);
    sensor_hold(1'b0, rnd ? int'($urandom_range(12, 16)) : 15);
    for (int i = 39; i >= 0; i--) begin
      lo = rnd ? int'($urandom_range(6, 12)) : 10;
      if (f[i]) hi = rnd ? int'($urandom_range(13, 18)) : 14;
      else      hi = rnd ? int'($urandom_range(4, 8)) : 6;
      sensor_hold(1'b1, lo);
      if (i == retrig_bit) begin
        sense_low = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        sensor_hold(1'b0, hi - 2);
      end else begin
        sensor_hold(1'b0, hi);
      end
    end
  endtask

  task automatic end_frame_and_check(input logic [39:0] f, input string tag);
    logic acc;
    acc = model_accept(f);
    if (acc) begin
      exp_q.push_back(f);
      model_data = f;
    end
    sense_low = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_valid_not_early"}, 40'(data_valid), 40'd0);
    chk({tag, "_error_not_early"}, 40'(error), 40'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 40'(data_valid), 40'(acc));
    chk({tag, "_error"}, 40'(error), 40'(!acc));
    chk({tag, "_busy_in_pulse"}, 40'(busy), 40'd1);
    chk({tag, "_data"}, data_sensor, model_data);
    @(negedge clk);
    chk({tag, "_valid_single"}, 40'(data_valid), 40'd0);
    chk({tag, "_busy_drop"}, 40'(busy), 40'd0);
    sensor_hold(1'b1, 10);
    sensor_hold(1'b0, 3);
  endtask

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [39:0] f;
    int lows, e0, d0, busy_seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_valid", 40'(data_valid), 40'd0);
    chk("rst_error", 40'(error), 40'd0);
    chk("rst_data", data_sensor, 40'd0);
    chk("rst_line_released", 40'(sensor_line), 40'd1);
    rst = 1'b0;
    @(negedge clk);

    // directed frame with good checksum
    f = 40'h2800190041;
    start_txn();
    wait_host_start();
    send_frame(f, 1'b0, -1);
    end_frame_and_check(f, "frame41");

    // checksum off by one
    f = 40'h2800190042;
    start_txn();
    wait_host_start();
    send_frame(f, 1'b0, -1);
    end_frame_and_check(f, "frame42");

    // reset in the middle of the start pulse
    start_txn();
    repeat (5) @(negedge clk);
    chk("mid_line_low", 40'(sensor_line), 40'd0);
    chk("mid_busy", 40'(busy), 40'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_line_released", 40'(sensor_line), 40'd1);
    chk("midrst_busy", 40'(busy), 40'd0);
    chk("midrst_data", data_sensor, 40'd0);
    model_data = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // no sensor response: timeout measured from host release
    e0 = err_cnt;
    start_txn();
    wait_host_start();
    lows = 0;
    for (int k = 0; k < RELEASE + TIMEOUT + 1; k++) begin
      if (sensor_line !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("to_no_early_error", 40'(error), 40'd0);
    @(negedge clk);
    chk("to_error", 40'(error), 40'd1);
    chk("to_busy_in_pulse", 40'(busy), 40'd1);
    chk("to_no_valid", 40'(data_valid), 40'd0);
    @(negedge clk);
    chk("to_error_single", 40'(error), 40'd0);
    chk("to_busy_drop", 40'(busy), 40'd0);
    chk("to_line_released", 40'(lows), 40'd0);
    chk("to_data_kept", data_sensor, model_data);
    chk("to_one_error", 40'(err_cnt - e0), 40'd1);

    // second enable edge during a bit, then enable held high
    d0 = dv_cnt;
    f = make_frame(1'b1);
    enable = 1'b1;
    @(negedge clk);
    wait_host_start();
    send_frame(f, 1'b1, 20);
    end_frame_and_check(f, "retrig");
    busy_seen = 0;
    repeat (60) begin
      if (busy) busy_seen++;
      @(negedge clk);
    end
    chk("retrig_no_restart", 40'(busy_seen), 40'd0);
    chk("retrig_one_valid", 40'(dv_cnt - d0), 40'd1);
    enable = 1'b0;
    @(negedge clk);

    // checksum wrap-around
    f = {8'hFF, 8'h01, 8'h80, 8'h80, 8'h00};
    start_txn();
    wait_host_start();
    send_frame(f, 1'b0, -1);
    end_frame_and_check(f, "wrap");

    // randomized frames and timing
    for (int r = 0; r < 4; r++) begin
      f = make_frame(1'($urandom_range(0, 1)));
      start_txn();
      wait_host_start();
      send_frame(f, 1'b1, -1);
      end_frame_and_check(f, "rand");
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    chk("valid_error_exclusive", 40'(both_cnt), 40'd0);
    chk("state_observed_moving", 40'(state_moves != 0), 40'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
